// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
//   8N1 UART receiver, LSB first. Reconstructs bytes from the RX pin and
//   presents them on a valid/ready byte interface. It uses the same bit-period
//   parameter as uart_transmitter, so both blocks can share one baud setting.
//
// Ports
//   sysclk        in   system clock
//   rst_n         in   asynchronous active-low reset
//   UART_RX       in   asynchronous serial line, idles high
//   data          out  received byte, valid while data_valid is high
//   data_valid    out  byte available, held until accepted
//   data_ready    in   consumer accepts data when data_valid & data_ready
//   framing_error out  1-cycle pulse when the stop bit samples 0
//   overrun       out  1-cycle pulse when a completed byte is dropped
//
// Build option
//   UART_RX_MAJORITY_VOTE_EN  when defined, each sample point takes a 2-of-3
//                             majority over three consecutive cycles centred
//                             on the nominal point. Everything after the
//                             start sample is shifted one cycle later.
// -----------------------------------------------------------------------------
module uart_receiver #(
    parameter int BAUD_LENGTH_IN_CYCLES = 125000000 / 115200,
    parameter int HALF_BAUD             = BAUD_LENGTH_IN_CYCLES / 2
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic       UART_RX,
    output logic [7:0] data,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       framing_error,
    output logic       overrun
);

    localparam int CW = $clog2(BAUD_LENGTH_IN_CYCLES) + 1;

`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int VOTE_DLY = 1;
`else
    localparam int VOTE_DLY = 0;
`endif

    // The start sample is pushed one cycle later in vote mode. After that,
    // every bit period stays BAUD_LENGTH_IN_CYCLES long, so the data and stop
    // decisions inherit the same one-cycle shift without any extra compare.
    localparam logic [CW-1:0] START_PT = CW'(HALF_BAUD - 1 + VOTE_DLY);
    localparam logic [CW-1:0] BIT_PT   = CW'(BAUD_LENGTH_IN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t          r_state;
    logic            r_sync1;
    logic            r_sync2;
    logic            r_rx_prev;
    logic [CW-1:0]   r_count;
    logic [2:0]      r_index;
    logic [7:0]      r_shift;

    logic            w_rx;
    logic            w_fall;
    logic            w_bit;

    assign w_rx   = r_sync2;
    assign w_fall = r_rx_prev & ~r_sync2;

`ifdef UART_RX_MAJORITY_VOTE_EN
    // r_hist holds rx from the two preceding cycles, so at the decision cycle
    // the vote covers (count-1, count, count+1) around the nominal point.
    logic [1:0] r_hist;
    assign w_bit = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rx) | (r_hist[0] & w_rx);
`else
    assign w_bit = w_rx;
`endif

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1       <= 1'b1;
            r_sync2       <= 1'b1;
            r_rx_prev     <= 1'b1;
            r_state       <= S_IDLE;
            r_count       <= '0;
            r_index       <= '0;
            r_shift       <= '0;
            data          <= '0;
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
`ifdef UART_RX_MAJORITY_VOTE_EN
            r_hist        <= '1;
`endif
        end else begin
            r_sync1   <= UART_RX;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
`ifdef UART_RX_MAJORITY_VOTE_EN
            r_hist    <= {r_hist[0], w_rx};
`endif
            framing_error <= 1'b0;
            overrun       <= 1'b0;

            // Acceptance; a delivery later in this block overrides it.
            if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    r_count <= '0;
                    r_index <= '0;
                    if (w_fall) begin
                        r_state <= S_START;
                    end
                end

                S_START: begin
                    if (r_count == START_PT) begin
                        r_count <= '0;
                        r_index <= '0;
                        r_state <= w_bit ? S_IDLE : S_DATA;
                    end else begin
                        r_count <= r_count + CW'(1);
                    end
                end

                S_DATA: begin
                    if (r_count == BIT_PT) begin
                        r_count          <= '0;
                        r_shift[r_index] <= w_bit;
                        r_index          <= r_index + 3'd1;
                        if (r_index == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_count <= r_count + CW'(1);
                    end
                end

                S_STOP: begin
                    if (r_count == BIT_PT) begin
                        r_count <= '0;
                        r_index <= '0;
                        if (w_bit) begin
                            if (!data_valid || data_ready) begin
                                data       <= r_shift;
                                data_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                            r_state <= S_IDLE;
                        end else begin
                            framing_error <= 1'b1;
                            r_state       <= S_BREAK;
                        end
                    end else begin
                        r_count <= r_count + CW'(1);
                    end
                end

                S_BREAK: begin
                    r_count <= '0;
                    r_index <= '0;
                    if (w_rx) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_count <= '0;
                    r_index <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
